// File: rtl/mig_rr_arbiter.sv
// Round-robin arbiter sharing one MIG 7-series user interface among N_PORTS line requesters.
// Optional read watchdog is enabled by defining MIG_ARB_TIMEOUT_EN.
`ifndef WDFP
`define WDFP 128
`endif

module mig_rr_arbiter #(
  parameter int N_PORTS        = 4,
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = `WDFP,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_PORTS-1:0]            req_i,
  input  logic [N_PORTS-1:0]            req_rw_i,
  input  logic [N_PORTS*ADDR_W-1:0]     req_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]     req_wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0]   req_mask_i,
  output logic [N_PORTS-1:0]            done_o,
  output logic [DATA_W-1:0]             rdata_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic                          app_en,
  output logic [2:0]                    app_cmd,
  output logic [ADDR_W-1:0]             app_addr,
  output logic [DATA_W-1:0]             app_wdf_data,
  output logic [DATA_W/8-1:0]           app_wdf_mask,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  input  logic                          app_rdy,
  input  logic                          app_wdf_rdy,
  input  logic                          app_rd_data_valid,
  input  logic [DATA_W-1:0]             app_rd_data,
  output logic                          app_sr_req,
  output logic                          app_ref_req,
  output logic                          app_zq_req
);

  localparam int PW = $clog2(N_PORTS);
  localparam int MW = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   last;
  logic [PW-1:0]   gnt;
  logic            rw_q;
  logic [PW-1:0]   pick;
  logic            found;
  logic            accept;

  logic [ADDR_W-1:0] addr_a  [N_PORTS];
  logic [DATA_W-1:0] wdata_a [N_PORTS];
  logic [MW-1:0]     mask_a  [N_PORTS];

  for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
    assign addr_a[k]  = req_addr_i[k*ADDR_W +: ADDR_W];
    assign wdata_a[k] = req_wdata_i[k*DATA_W +: DATA_W];
    assign mask_a[k]  = req_mask_i[k*MW +: MW];
  end

  // Scan last+1, last+2, ... so the most recently served port has lowest priority.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= N_PORTS; i++) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(last) + i) % N_PORTS);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign accept      = app_rdy && (!rw_q || app_wdf_rdy);
  assign busy_o      = (state != IDLE);
  assign app_sr_req  = 1'b0;
  assign app_ref_req = 1'b0;
  assign app_zq_req  = 1'b0;

`ifdef MIG_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_o  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      last         <= PW'(N_PORTS - 1);
      gnt          <= '0;
      rw_q         <= 1'b0;
      done_o       <= '0;
      rdata_o      <= '0;
      app_en       <= 1'b0;
      app_cmd      <= 3'b000;
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
`ifdef MIG_ARB_TIMEOUT_EN
      tmo_cnt      <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt          <= pick;
            last         <= pick;
            rw_q         <= req_rw_i[pick];
            app_en       <= 1'b1;
            app_cmd      <= req_rw_i[pick] ? 3'b000 : 3'b001;
            app_addr     <= addr_a[pick];
            app_wdf_data <= wdata_a[pick];
            app_wdf_mask <= mask_a[pick];
            app_wdf_wren <= req_rw_i[pick];
            app_wdf_end  <= req_rw_i[pick];
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // Command fields stay untouched until the MIG accepts them.
          if (accept) begin
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            if (rw_q) begin
              done_o <= N_PORTS'(1) << gnt;
              state  <= RESP;
            end else begin
`ifdef MIG_ARB_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state  <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (app_rd_data_valid) begin
            rdata_o <= app_rd_data;
            done_o  <= N_PORTS'(1) << gnt;
            state   <= RESP;
          end
`ifdef MIG_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            rdata_o   <= '0;
            timeout_o <= 1'b1;
            done_o    <= N_PORTS'(1) << gnt;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          done_o <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_rr_arbiter.sv
// Directed self-checking bench for mig_rr_arbiter (4 ports, 28-bit address, 128-bit lines).
`timescale 1ns/1ps
module tb_mig_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N-1:0]      req_i;
  logic [N-1:0]      req_rw_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N*MW-1:0]   req_mask_i;
  logic [N-1:0]      done_o;
  logic [DW-1:0]     rdata_o;
  logic              busy_o;
  logic              timeout_o;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [AW-1:0]     app_addr;
  logic [DW-1:0]     app_wdf_data;
  logic [MW-1:0]     app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic [DW-1:0]     app_rd_data;
  logic              app_sr_req;
  logic              app_ref_req;
  logic              app_zq_req;

  int total = 0;
  int bad   = 0;

  mig_rr_arbiter #(
    .N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .req_rw_i(req_rw_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_mask_i(req_mask_i),
    .done_o(done_o), .rdata_o(rdata_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
    .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_port(input int p, input logic rw, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_rw_i[p]            = rw;
    req_addr_i[p*AW +: AW] = a;
    req_wdata_i[p*DW +: DW] = d;
    req_mask_i[p*MW +: MW] = m;
  endtask

  logic [DW-1:0] pdata [N];
  logic [MW-1:0] pmask [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] mem_line;
  logic          seen_done;
  int            p;

  initial begin
    pdata[0] = {4{32'h1111_1111}}; pmask[0] = 16'h000F; paddr[0] = 28'h0000100;
    pdata[1] = {4{32'h2222_2222}}; pmask[1] = 16'h00F0; paddr[1] = 28'h0000200;
    pdata[2] = {4{32'h3333_3333}}; pmask[2] = 16'h0F00; paddr[2] = 28'h0000300;
    pdata[3] = {4{32'h4444_4444}}; pmask[3] = 16'hF000; paddr[3] = 28'h0000400;

    rst_ni = 1'b0; req_i = '0; req_rw_i = '0; req_addr_i = '0; req_wdata_i = '0;
    req_mask_i = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    repeat (3) tick();

    // Reset state
    check("rst_app_en", app_en, 0);
    check("rst_app_cmd", app_cmd, 0);
    check("rst_app_addr", app_addr, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_wren", {app_wdf_wren, app_wdf_end}, 0);
    check("rst_timeout", timeout_o, 0);
    check("tied_reqs", {app_sr_req, app_ref_req, app_zq_req}, 0);
    rst_ni = 1'b1;
    tick();

    // Single read on port 2, data returned 12 cycles later
    set_port(2, 1'b0, 28'h0000040, '0, '0);
    req_i = 4'b0100;
    tick();
    check("rd_app_en", app_en, 1);
    check("rd_app_cmd", app_cmd, 3'b001);
    check("rd_app_addr", app_addr, 28'h40);
    check("rd_wren_low", app_wdf_wren, 0);
    check("rd_busy", busy_o, 1);
    tick();
    check("rd_en_drop", app_en, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      seen_done = seen_done | (|done_o);
      tick();
    end
    check("rd_no_early_done", seen_done, 0);
    app_rd_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check("rd_done", done_o, 4'b0100);
    check("rd_rdata", rdata_o, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    req_i = '0;
    tick();
    check("rd_done_one_cycle", done_o, 0);
    check("rd_idle", busy_o, 0);

    // Reset during WAIT_RD abandons the transaction
    set_port(1, 1'b0, 28'h0000080, '0, '0);
    req_i = 4'b0010;
    tick();
    tick();
    check("rstmid_busy_before", busy_o, 1);
    rst_ni = 1'b0;
    req_i  = '0;
    #2;
    rst_ni = 1'b1;
    check("rstmid_busy_after", busy_o, 0);
    seen_done = 1'b0;
    tick();
    app_rd_data = 128'h0123;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    seen_done = seen_done | (|done_o);
    tick();
    seen_done = seen_done | (|done_o);
    check("rstmid_no_done", seen_done, 0);
    check("rstmid_idle", busy_o, 0);
    check("rstmid_rdata", rdata_o, 0);

    // All four ports write continuously: grants 0,1,2,3,0
    for (int k = 0; k < N; k++) set_port(k, 1'b1, paddr[k], pdata[k], pmask[k]);
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      p = k % N;
      tick();
      check($sformatf("rr%0d_en", k), {app_en, app_wdf_wren, app_wdf_end}, 3'b111);
      check($sformatf("rr%0d_cmd", k), app_cmd, 3'b000);
      check($sformatf("rr%0d_addr", k), app_addr, paddr[p]);
      check($sformatf("rr%0d_data", k), app_wdf_data, pdata[p]);
      check($sformatf("rr%0d_mask", k), app_wdf_mask, pmask[p]);
      tick();
      check($sformatf("rr%0d_done", k), done_o, 4'b0001 << p);
      req_i[p] = 1'b0;
      tick();
      if (k < 4) req_i[p] = 1'b1;
      else req_i = '0;
    end

    // app_rdy stalls ISSUE for 5 cycles
    app_rdy = 1'b0;
    set_port(3, 1'b1, 28'h0ABCDEF, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 16'h0000);
    req_i = 4'b1000;
    tick();
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_en", i), {app_en, app_wdf_wren}, 2'b11);
      check($sformatf("stall%0d_addr", i), app_addr, 28'h0ABCDEF);
      check($sformatf("stall%0d_data", i), app_wdf_data,
            128'hCAFE_F00D_0000_1111_2222_3333_4444_5555);
      seen_done = seen_done | (|done_o);
      if (i < 4) tick();
    end
    check("stall_no_done", seen_done, 0);
    app_rdy = 1'b1;
    tick();
    check("stall_done", done_o, 4'b1000);
    req_i = '0;
    tick();
    check("stall_single_pulse", done_o, 0);

    // Masked write then read back through a one-line memory model
    mem_line = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    set_port(0, 1'b1, 28'h0000200, {16{8'hA5}}, 16'hFFF0);
    req_i = 4'b0001;
    tick();
    check("mask_pass", app_wdf_mask, 16'hFFF0);
    if (app_en && app_wdf_wren)
      for (int b = 0; b < MW; b++)
        if (!app_wdf_mask[b]) mem_line[b*8 +: 8] = app_wdf_data[b*8 +: 8];
    tick();
    check("mask_wr_done", done_o, 4'b0001);
    req_i = '0;
    tick();
    set_port(0, 1'b0, 28'h0000200, '0, '0);
    req_i = 4'b0001;
    tick();
    check("mask_rd_cmd", app_cmd, 3'b001);
    check("mask_rd_addr", app_addr, 28'h200);
    tick();
    app_rd_data = mem_line;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check("mask_rd_done", done_o, 4'b0001);
    check("mask_rdata", rdata_o, 128'h0011_2233_4455_6677_8899_AABB_A5A5_A5A5);
    req_i = '0;
    tick();

`ifdef MIG_ARB_TIMEOUT_EN
    // Read that the MIG never answers
    set_port(1, 1'b0, 28'h0000500, '0, '0);
    req_i = 4'b0010;
    tick();
    tick();
    seen_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_done = seen_done | (|done_o);
    end
    check("tmo_no_early_done", seen_done, 0);
    check("tmo_flag_before", timeout_o, 0);
    tick();
    check("tmo_done", done_o, 4'b0010);
    check("tmo_rdata", rdata_o, 0);
    check("tmo_flag", timeout_o, 1);
    req_i = '0;
    tick();
    tick();
    check("tmo_sticky", timeout_o, 1);
    check("tmo_idle", busy_o, 0);
`else
    check("timeout_tied", timeout_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
